regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter dtype, default 16, meaning data width in bits per register.
REQ-002 SHALL have parameter nregs, default 8, meaning the number of registers (power of two, >=2).
REQ-003 SHALL have parameter addr_len, default 3, meaning address width, equal to log2(nregs).
REQ-004 SHALL have parameter nread, default 2, meaning the number of independent read ports (1..4).
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning the asynchronous, active-low reset.
REQ-007 SHALL have port clk_en, input, 1, meaning the global enable; when low, no state changes except by reset.
REQ-008 SHALL have port clear, input, 1, meaning a request to zero all registers.
REQ-009 SHALL have port ready, output, 1, meaning no clear sequence is running.
REQ-010 SHALL have port wr_en, input, 1, meaning the write strobe.
REQ-011 SHALL have port wr_addr, input, addr_len, meaning the write address.
REQ-012 SHALL have port wr_data, input, dtype, meaning the write data.
REQ-013 SHALL have port rd_addr, input, nread*addr_len, meaning packed read addresses, with port k at bits [k*addr_len +: addr_len].
REQ-014 SHALL have port rd_data, output, nread*dtype, meaning packed read data, with port k at bits [k*dtype +: dtype].

Function
REQ-015 SHALL have storage declared as nregs entries of dtype bits each (entry count and width not swapped), with no per-entry reset.
REQ-016 SHALL make each read combinational, so rd_data[k] reflects storage[rd_addr[k]] in the same cycle.
REQ-017 SHALL write wr_data to storage[wr_addr] at the rising edge when clk_en, wr_en and ready are all 1; it SHALL NOT write otherwise.
REQ-018 SHALL implement a clear FSM with states IDLE and CLEAR, plus a clear counter of addr_len bits.
REQ-019 SHALL move the FSM from IDLE to CLEAR, with the counter set to 0, when clk_en=1 and clear=1.
REQ-020 SHALL, in CLEAR with clk_en=1, write 0 to storage[counter] and increment the counter each cycle; the transition back to IDLE SHALL occur on the cycle that writes entry nregs-1.
REQ-021 SHALL hold the counter and FSM state while clk_en=0 in CLEAR.
REQ-022 SHALL make a full clear take exactly nregs enabled cycles; ready SHALL be 0 throughout CLEAR and return to 1 in the cycle after the last entry is zeroed.
REQ-023 SHALL drop user writes while ready=0, with no queuing, and SHALL ignore clear while in CLEAR (no restart).
REQ-024 SHALL give clear priority when clear and wr_en are asserted together in IDLE: the write is performed, then the sequence zeroes it.
REQ-025 SHALL have the counter wrap to 0 on leaving CLEAR, with no out-of-range address generated.

Reset
REQ-026 SHALL, on reset low, force the FSM to CLEAR, the counter to 0 and ready to 0, asynchronously.
REQ-027 SHALL, after reset deasserts, run a complete clear sequence, so all registers read 0 once ready first rises.
REQ-028 SHALL, on reset asserted mid-sequence, restart the sequence from entry 0.

Configuration
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, make a read port whose rd_addr equals wr_addr return wr_data combinationally while a write is being accepted.
REQ-030 SHALL, without REGFILE_BYPASS_EN, make reads return only stored contents, with new data visible the cycle after the write.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, CLEAR) and the default parameter constants in package regfile_pkg.
REQ-032 SHALL implement the FSM and counter in sub-module regfile_clear_seq, which outputs ready, a clear write enable and a clear address.
REQ-033 SHALL keep the storage array and read multiplexers in regfile_mp.

Verification
REQ-034 SHALL cover reset release: after nregs=8 enabled cycles ready=1, and all rd_data read 0x0000.
REQ-035 SHALL cover write then read: write 0xBEEF to reg 5, then read it on ports 0 and 1 the next cycle, returning 0xBEEF on both.
REQ-036 SHALL cover same-cycle bypass: write 0x1234 to reg 2 with rd_addr0=2; the port returns 0x1234 in that cycle with REGFILE_BYPASS_EN, and the old value without it.
REQ-037 SHALL cover clear with clk_en gaps: clear with clk_en toggling 1/0 gives ready=0 for 16 cycles, after which all registers are 0.
REQ-038 SHALL cover a write during clear: wr_en to reg 7 with 0xAAAA while ready=0 leaves reg 7 at 0 after ready rises.
REQ-039 SHALL cover reset mid-clear: reset low at counter=4 followed by release gives a full 8-cycle sequence restarted from entry 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sequencer state type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DTYPE_DEF    = 16;
  localparam int unsigned NREGS_DEF    = 8;
  localparam int unsigned ADDR_LEN_DEF = 3;
  localparam int unsigned NREAD_DEF    = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register address once, issuing zero-writes,
// and reports ready while no sweep is in progress.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned nregs    = NREGS_DEF,
  parameter int unsigned addr_len = ADDR_LEN_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clk_en_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic                clr_we_c,
  output logic [addr_len-1:0] clr_addr_o
);

  localparam logic [addr_len-1:0] LastAddr = addr_len'(nregs - 1);

  clr_state_e          state_q, state_d;
  logic [addr_len-1:0] cnt_q, cnt_d;
  logic                ready_q, ready_d;

  // Reset lands in CLEAR so storage is swept after every reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    if (clk_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          // Counter wraps to 0 naturally on the last entry.
          clr_we_c = 1'b1;
          cnt_d    = cnt_q + addr_len'(1);
          if (cnt_q == LastAddr) begin
            state_d = IDLE;
          end
        end
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  assign ready_o    = ready_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a self-clearing sequencer.
// Define REGFILE_BYPASS_EN to forward accepted write data to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned dtype    = DTYPE_DEF,
  parameter int unsigned nregs    = NREGS_DEF,
  parameter int unsigned addr_len = ADDR_LEN_DEF,
  parameter int unsigned nread    = NREAD_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      clear,
  output logic                      ready,
  input  logic                      wr_en,
  input  logic [addr_len-1:0]       wr_addr,
  input  logic [dtype-1:0]          wr_data,
  input  logic [nread*addr_len-1:0] rd_addr,
  output logic [nread*dtype-1:0]    rd_data
);

  logic [dtype-1:0]    mem_q [nregs];
  logic                clr_we;
  logic [addr_len-1:0] clr_addr;
  logic                wr_accept;

  regfile_clear_seq #(
    .nregs    (nregs),
    .addr_len (addr_len)
  ) u_clear_seq (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clk_en_i   (clk_en),
    .clear_i    (clear),
    .ready_o    (ready),
    .clr_we_c   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign wr_accept = clk_en & wr_en & ready;

  // Storage has no reset; the sequencer zeroes it after every reset release.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < nread; k++) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (rd_addr[k*addr_len +: addr_len] == wr_addr)) begin
        rd_data[k*dtype +: dtype] = wr_data;
      end else begin
        rd_data[k*dtype +: dtype] = mem_q[rd_addr[k*addr_len +: addr_len]];
      end
`else
      rd_data[k*dtype +: dtype] = mem_q[rd_addr[k*addr_len +: addr_len]];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: spec-level model plus directed vectors.
module tb_regfile_mp;

  localparam int NREGS = 8;
  localparam int NREAD = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        clear;
  logic        ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: stored words, and how many entries the pending sweep still has to zero.
  logic [15:0] m_mem [NREGS];
  int          clear_left;

  logic [2:0]  cmp_a;
  logic [15:0] cmp_e;
  int          n;

  regfile_mp #(
    .dtype    (16),
    .nregs    (8),
    .addr_len (3),
    .nread    (2)
  ) dut (
    .clock   (clk),
    .reset   (rst_n),
    .clk_en  (clk_en),
    .clear   (clear),
    .ready   (ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_left <= NREGS;
    end else if (clk_en) begin
      if (clear_left > 0) begin
        m_mem[NREGS - clear_left] <= 16'h0000;
        clear_left <= clear_left - 1;
      end else begin
        if (wr_en) m_mem[wr_addr] <= wr_data;
        if (clear) clear_left <= NREGS;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_ready", {15'd0, ready}, {15'd0, (clear_left == 0)});
      for (int k = 0; k < NREAD; k++) begin
        cmp_a = rd_addr[k*3 +: 3];
        if (BYP && clk_en && wr_en && (clear_left == 0) && (cmp_a == wr_addr))
          cmp_e = wr_data;
        else
          cmp_e = m_mem[cmp_a];
        if (!$isunknown(cmp_e))
          chk($sformatf("cmp_rd%0d_a%0d", k, cmp_a), rd_data[k*16 +: 16], cmp_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic count_busy(input int bound, output int cnt);
    cnt = 0;
    #2;
    while (ready !== 1'b1 && cnt < bound) begin
      cnt++;
      step();
      #2;
    end
  endtask

  task automatic chk_all_zero(input string name);
    step();
    for (int i = 0; i < NREGS; i++) begin
      set_rd(3'(i), 3'(NREGS - 1 - i));
      #1;
      chk($sformatf("%s_p0_r%0d", name, i), rd_data[15:0], 16'h0000);
      chk($sformatf("%s_p1_r%0d", name, NREGS - 1 - i), rd_data[31:16], 16'h0000);
    end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; clear = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < NREGS; i++) m_mem[i] = 'x;
    step();
    step();
    chk_en = 1'b1;
    #2;
    chk("reset_ready", {15'd0, ready}, 16'd0);

    // Reset release: full sweep of 8 enabled cycles, then everything reads 0.
    step();
    rst_n = 1'b1;
    count_busy(30, n);
    chk("reset_busy_cycles", 16'(n), 16'd8);
    chk_all_zero("after_reset");

    // Write 0xBEEF to reg 5, read it on both ports next cycle.
    step();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; set_rd(3'd5, 3'd5);
    #2;
    chk("beef_same_cycle_p0", rd_data[15:0], BYP ? 16'hBEEF : 16'h0000);
    step();
    wr_en = 1'b0;
    #2;
    chk("beef_next_p0", rd_data[15:0], 16'hBEEF);
    chk("beef_next_p1", rd_data[31:16], 16'hBEEF);

    // Same-cycle bypass on reg 2.
    step();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; set_rd(3'd2, 3'd5);
    #2;
    chk("bypass_p0", rd_data[15:0], BYP ? 16'h1234 : 16'h0000);
    chk("bypass_p1", rd_data[31:16], 16'hBEEF);
    step();
    wr_en = 1'b0;
    #2;
    chk("bypass_next_p0", rd_data[15:0], 16'h1234);

    // clk_en low blocks both writes and clear.
    step();
    clk_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777; clear = 1'b1;
    step();
    clk_en = 1'b1; wr_en = 1'b0; clear = 1'b0; set_rd(3'd1, 3'd2);
    #2;
    chk("gated_ready", {15'd0, ready}, 16'd1);
    chk("gated_no_write_p0", rd_data[15:0], 16'h0000);
    chk("gated_keep_p1", rd_data[31:16], 16'h1234);

    // Preload, then clear with clk_en toggling.
    step();
    wr(3'd0, 16'h1111);
    wr(3'd1, 16'h2222);
    wr(3'd3, 16'h3333);
    wr(3'd6, 16'h6666);
    set_rd(3'd3, 3'd6);
    #1;
    chk("preload_r3", rd_data[15:0], 16'h3333);
    chk("preload_r6", rd_data[31:16], 16'h6666);
    clear = 1'b1;
    step();
    clear = 1'b0; clk_en = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (ready === 1'b1) break;
      n++;
      step();
      clk_en = ~clk_en;
    end
    clk_en = 1'b1;
    chk("gap_clear_busy_cycles", 16'(n), 16'd16);
    chk_all_zero("after_gap_clear");

    // Writes and clear requests while busy are dropped.
    step();
    wr(3'd7, 16'h5555);
    clear = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hAAAA;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (ready === 1'b1) break;
      n++;
      if (c == 2) clear = 1'b0;
      if (c == 3) wr_addr = 3'd0;
      step();
    end
    wr_en = 1'b0; clear = 1'b0;
    chk("busy_write_cycles", 16'(n), 16'd8);
    set_rd(3'd7, 3'd0);
    #1;
    chk("busy_write_r7", rd_data[15:0], 16'h0000);
    chk("busy_write_r0", rd_data[31:16], 16'h0000);

    // Clear and write together: write lands, then the sweep zeroes it.
    step();
    clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444; set_rd(3'd4, 3'd4);
    step();
    clear = 1'b0; wr_en = 1'b0;
    count_busy(30, n);
    chk("prio_busy_cycles", 16'(n), 16'd8);
    chk("prio_r4", rd_data[15:0], 16'h0000);

    // Reset at counter 4 restarts a full 8-cycle sweep.
    step();
    wr(3'd3, 16'h3333);
    wr(3'd6, 16'h6666);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #2;
    chk("mid_reset_ready", {15'd0, ready}, 16'd0);
    step();
    step();
    rst_n = 1'b1;
    count_busy(30, n);
    chk("mid_reset_busy_cycles", 16'(n), 16'd8);
    chk_all_zero("after_mid_reset");

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
